// File: rtl/sc_statemachine_playerctrl.sv
// rtl/sc_statemachine_playerctrl.sv - NPLAYERS move FSMs with position limits and auto-repeat, plus global start/clear FSM
module sc_statemachine_playerctrl #(
    parameter int NPLAYERS      = 2,
    parameter int POS_W         = 4,
    parameter int POS_MAX       = 7,
    parameter int POS_INIT      = 3,
    parameter int CNT_W         = 24,
    parameter int HOLD_CYCLES   = 0,
    parameter int REPEAT_CYCLES = 1
) (
    input  logic                      SC_STATEMACHINE_PLAYERCTRL_CLOCK_50,
    input  logic                      SC_STATEMACHINE_PLAYERCTRL_RESET_InHigh,
    input  logic                      SC_STATEMACHINE_PLAYERCTRL_startButton_InLow,
    input  logic [NPLAYERS-1:0]       SC_STATEMACHINE_PLAYERCTRL_leftButton_InLow,
    input  logic [NPLAYERS-1:0]       SC_STATEMACHINE_PLAYERCTRL_rightButton_InLow,
    output logic                      SC_STATEMACHINE_PLAYERCTRL_clear_OutLow,
    output logic [2*NPLAYERS-1:0]     SC_STATEMACHINE_PLAYERCTRL_shiftselection_Out,
    output logic [POS_W*NPLAYERS-1:0] SC_STATEMACHINE_PLAYERCTRL_position_Out,
    output logic [NPLAYERS-1:0]       SC_STATEMACHINE_PLAYERCTRL_busy_Out
);
    typedef enum logic [2:0] {G_RESET, G_START, G_RUN, G_INIT, G_WAITREL} g_state_t;
    typedef enum logic [1:0] {P_IDLE, P_MOVE, P_HELD} p_state_t;

    localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_INIT_V = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
    localparam logic [CNT_W-1:0] HOLD_TH    = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] REP_TH     = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               AUTO_EN    = (HOLD_CYCLES > 0);

    g_state_t         g_state_q, g_state_d;
    p_state_t         p_state_q [NPLAYERS];
    p_state_t         p_state_d [NPLAYERS];
    logic [POS_W-1:0] pos_q     [NPLAYERS];
    logic [POS_W-1:0] pos_d     [NPLAYERS];
    logic [CNT_W-1:0] timer_q   [NPLAYERS];
    logic [CNT_W-1:0] timer_d   [NPLAYERS];
    logic [NPLAYERS-1:0] dir_q, dir_d;   // 1 = left
    logic [NPLAYERS-1:0] rep_q, rep_d;
    logic [NPLAYERS-1:0] arm_q, arm_d;
    logic [NPLAYERS-1:0] l_dn, r_dn;
    logic                start_dn, g_run, g_init;

    assign l_dn     = ~SC_STATEMACHINE_PLAYERCTRL_leftButton_InLow;
    assign r_dn     = ~SC_STATEMACHINE_PLAYERCTRL_rightButton_InLow;
    assign start_dn = ~SC_STATEMACHINE_PLAYERCTRL_startButton_InLow;
    assign g_run    = (g_state_q == G_RUN);
    assign g_init   = (g_state_q == G_INIT);

    always_ff @(posedge SC_STATEMACHINE_PLAYERCTRL_CLOCK_50) begin
        if (SC_STATEMACHINE_PLAYERCTRL_RESET_InHigh) begin
            g_state_q <= G_RESET;
            dir_q     <= '0;
            rep_q     <= '0;
            arm_q     <= '0;
            for (int i = 0; i < NPLAYERS; i++) begin
                p_state_q[i] <= P_IDLE;
                pos_q[i]     <= POS_INIT_V;
                timer_q[i]   <= '0;
            end
        end else begin
            g_state_q <= g_state_d;
            dir_q     <= dir_d;
            rep_q     <= rep_d;
            arm_q     <= arm_d;
            p_state_q <= p_state_d;
            pos_q     <= pos_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        g_state_d = g_state_q;
        case (g_state_q)
            G_RESET:   g_state_d = G_START;
            G_START:   g_state_d = G_RUN;
            G_RUN:     if (start_dn) g_state_d = G_INIT;
            G_INIT:    g_state_d = G_WAITREL;
            G_WAITREL: if (!start_dn) g_state_d = G_RUN;
            default:   g_state_d = G_RESET;
        endcase
        SC_STATEMACHINE_PLAYERCTRL_clear_OutLow =
            !(g_state_q == G_RESET || g_state_q == G_START || g_state_q == G_INIT);
    end

    // A player only accepts a new press after seeing both buttons released since
    // reset or start/clear, so a button held across either cannot fire a move.
    always_comb begin
        p_state_d = p_state_q;
        pos_d     = pos_q;
        timer_d   = timer_q;
        dir_d     = dir_q;
        rep_d     = rep_q;
        arm_d     = arm_q | (~l_dn & ~r_dn);
        SC_STATEMACHINE_PLAYERCTRL_shiftselection_Out = '1;
        SC_STATEMACHINE_PLAYERCTRL_position_Out       = '0;
        SC_STATEMACHINE_PLAYERCTRL_busy_Out           = '0;
        for (int i = 0; i < NPLAYERS; i++) begin
            if (g_init) begin
                p_state_d[i] = P_IDLE;
                pos_d[i]     = POS_INIT_V;
                timer_d[i]   = '0;
                rep_d[i]     = 1'b0;
                arm_d[i]     = 1'b0;
            end else if (g_run) begin
                case (p_state_q[i])
                    P_IDLE: begin
                        if (!start_dn && arm_q[i] && (l_dn[i] ^ r_dn[i])) begin
                            dir_d[i]   = l_dn[i];
                            rep_d[i]   = 1'b0;
                            timer_d[i] = '0;
                            if (l_dn[i] ? (pos_q[i] < POS_MAX_V) : (pos_q[i] != '0))
                                p_state_d[i] = P_MOVE;
                            else
                                p_state_d[i] = P_HELD;
                        end
                    end
                    P_MOVE: begin
                        if (dir_q[i] && pos_q[i] < POS_MAX_V)
                            pos_d[i] = pos_q[i] + POS_ONE;
                        else if (!dir_q[i] && pos_q[i] != '0)
                            pos_d[i] = pos_q[i] - POS_ONE;
                        timer_d[i]   = '0;
                        p_state_d[i] = P_HELD;
                    end
                    P_HELD: begin
                        if (!l_dn[i] && !r_dn[i]) begin
                            p_state_d[i] = P_IDLE;
                        end else if (AUTO_EN && (dir_q[i] ? l_dn[i] : r_dn[i])) begin
                            if (timer_q[i] == (rep_q[i] ? REP_TH : HOLD_TH)) begin
                                timer_d[i] = '0;
                                if (dir_q[i] ? (pos_q[i] < POS_MAX_V) : (pos_q[i] != '0)) begin
                                    p_state_d[i] = P_MOVE;
                                    rep_d[i]     = 1'b1;
                                end
                            end else if (timer_q[i] != '1) begin
                                timer_d[i] = timer_q[i] + CNT_ONE;
                            end
                        end
                    end
                    default: p_state_d[i] = P_IDLE;
                endcase
            end
            if (g_run && p_state_q[i] == P_MOVE)
                SC_STATEMACHINE_PLAYERCTRL_shiftselection_Out[2*i +: 2] = dir_q[i] ? 2'b01 : 2'b10;
            SC_STATEMACHINE_PLAYERCTRL_position_Out[POS_W*i +: POS_W] = pos_q[i];
            SC_STATEMACHINE_PLAYERCTRL_busy_Out[i] = (p_state_q[i] != P_IDLE);
        end
    end
endmodule

// File: tb/tb_sc_statemachine_playerctrl.sv
// tb/tb_sc_statemachine_playerctrl.sv - directed bench: one-shot instance and auto-repeat instance
module tb_sc_statemachine_playerctrl;
    logic       clk = 1'b0;
    logic       rst_a, start_a, rst_b, start_b;
    logic [1:0] left_a, right_a, left_b, right_b;
    logic       clr_a, clr_b;
    logic [3:0] sh_a, sh_b;
    logic [7:0] pos_a, pos_b;
    logic [1:0] busy_a, busy_b;
    int checks = 0;
    int errors = 0;
    int pa0 = 0, pa1 = 0, pb0 = 0;
    int hits[$];

    always #5 clk = ~clk;

    sc_statemachine_playerctrl dut_a (
        .SC_STATEMACHINE_PLAYERCTRL_CLOCK_50(clk),
        .SC_STATEMACHINE_PLAYERCTRL_RESET_InHigh(rst_a),
        .SC_STATEMACHINE_PLAYERCTRL_startButton_InLow(start_a),
        .SC_STATEMACHINE_PLAYERCTRL_leftButton_InLow(left_a),
        .SC_STATEMACHINE_PLAYERCTRL_rightButton_InLow(right_a),
        .SC_STATEMACHINE_PLAYERCTRL_clear_OutLow(clr_a),
        .SC_STATEMACHINE_PLAYERCTRL_shiftselection_Out(sh_a),
        .SC_STATEMACHINE_PLAYERCTRL_position_Out(pos_a),
        .SC_STATEMACHINE_PLAYERCTRL_busy_Out(busy_a)
    );

    sc_statemachine_playerctrl #(.HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut_b (
        .SC_STATEMACHINE_PLAYERCTRL_CLOCK_50(clk),
        .SC_STATEMACHINE_PLAYERCTRL_RESET_InHigh(rst_b),
        .SC_STATEMACHINE_PLAYERCTRL_startButton_InLow(start_b),
        .SC_STATEMACHINE_PLAYERCTRL_leftButton_InLow(left_b),
        .SC_STATEMACHINE_PLAYERCTRL_rightButton_InLow(right_b),
        .SC_STATEMACHINE_PLAYERCTRL_clear_OutLow(clr_b),
        .SC_STATEMACHINE_PLAYERCTRL_shiftselection_Out(sh_b),
        .SC_STATEMACHINE_PLAYERCTRL_position_Out(pos_b),
        .SC_STATEMACHINE_PLAYERCTRL_busy_Out(busy_b)
    );

    always @(negedge clk) begin
        if (sh_a[1:0] != 2'b11) pa0++;
        if (sh_a[3:2] != 2'b11) pa1++;
        if (sh_b[1:0] != 2'b11) pb0++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_a0(input bit is_left);
        if (is_left) left_a = 2'b10; else right_a = 2'b10;
        repeat (2) tick();
        left_a = 2'b11; right_a = 2'b11;
        repeat (2) tick();
    endtask

    initial begin
        rst_a = 1; start_a = 1; left_a = 2'b11; right_a = 2'b11;
        rst_b = 1; start_b = 1; left_b = 2'b11; right_b = 2'b11;
        repeat (3) tick();
        chk("rst_clear", clr_a, 0);
        chk("rst_pos", pos_a, 8'h33);
        chk("rst_code", sh_a, 4'hF);
        chk("rst_busy", busy_a, 0);
        rst_a = 0; rst_b = 0;
        tick();
        chk("start_clear", clr_a, 0);
        tick();
        chk("run_clear", clr_a, 1);

        pa0 = 0; pa1 = 0;
        left_a = 2'b10;
        tick();
        chk("single_code", sh_a, 4'b1101);
        tick();
        chk("single_pos", pos_a, 8'h34);
        repeat (3) tick();
        left_a = 2'b11;
        tick();
        chk("single_pulses", pa0, 1);
        chk("single_p1", pa1, 0);
        chk("single_busy", busy_a, 0);

        repeat (3) press_a0(1);
        chk("to_max_pos", pos_a, 8'h37);
        left_a = 2'b10;
        repeat (4) tick();
        chk("max_busy", busy_a, 2'b01);
        chk("max_pulses", pa0, 4);
        chk("max_pos", pos_a, 8'h37);
        left_a = 2'b11;
        tick();
        chk("max_release", busy_a, 0);

        repeat (7) press_a0(0);
        chk("to_min_pos", pos_a, 8'h30);
        right_a = 2'b10;
        repeat (3) tick();
        chk("min_pulses", pa0, 11);
        chk("min_pos", pos_a, 8'h30);
        right_a = 2'b11;
        tick();

        left_a = 2'b10; right_a = 2'b10;
        repeat (3) tick();
        chk("both_pulses", pa0, 11);
        chk("both_busy", busy_a, 0);
        left_a = 2'b11; right_a = 2'b11;
        tick();

        start_a = 0; right_a = 2'b01;
        tick();
        chk("init_clear", clr_a, 0);
        chk("init_code", sh_a, 4'hF);
        tick();
        chk("waitrel_clear", clr_a, 1);
        chk("init_pos", pos_a, 8'h33);
        repeat (2) tick();
        right_a = 2'b11;
        tick();
        start_a = 1;
        repeat (2) tick();
        chk("start_p1_pulses", pa1, 0);
        chk("start_pos", pos_a, 8'h33);

        left_a = 2'b10; right_a = 2'b01;
        tick();
        chk("dual_code", sh_a, 4'b1001);
        tick();
        chk("dual_pos", pos_a, 8'h24);
        left_a = 2'b11; right_a = 2'b11;
        repeat (2) tick();

        for (int k = 0; k < 3; k++) begin
            right_b = 2'b10;
            repeat (2) tick();
            right_b = 2'b11;
            repeat (2) tick();
        end
        chk("b_min_pos", pos_b, 8'h30);
        left_b = 2'b10;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sh_b[1:0] == 2'b01) hits.push_back(k);
        end
        left_b = 2'b11;
        repeat (2) tick();
        chk("rep_count", hits.size(), 6);
        if (hits.size() == 6) begin
            chk("rep_t0", hits[0], 0);
            chk("rep_t1", hits[1], 5);
            chk("rep_t2", hits[2], 8);
            chk("rep_t5", hits[5], 17);
        end
        chk("rep_pos", pos_b, 8'h36);

        right_b = 2'b10;
        repeat (3) tick();
        chk("mid_pos", pos_b, 8'h35);
        rst_b = 1;
        tick();
        chk("mr_code", sh_b, 4'hF);
        chk("mr_pos", pos_b, 8'h33);
        chk("mr_clear", clr_b, 0);
        chk("mr_busy", busy_b, 0);
        rst_b = 0;
        pb0 = 0;
        repeat (6) tick();
        chk("mr_no_pulse", pb0, 0);
        chk("mr_hold_pos", pos_b, 8'h33);
        right_b = 2'b11;
        tick();
        right_b = 2'b10;
        tick();
        chk("mr_repress", sh_b, 4'b1110);
        right_b = 2'b11;
        repeat (3) tick();
        chk("mr_final_pos", pos_b, 8'h32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
